// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock-enable generator.
package clk_div_pkg;

  localparam int unsigned DEF_DIV_RESET = 4194304;

  function automatic int unsigned chw_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_SYNC,
    MODE_WRAP,
    MODE_COUNT
  } chan_mode_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor, registered tick and square wave.
// mode       | meaning
// MODE_HOLD  | channel disabled: counter parked at 0, outputs low, pending applied
// MODE_SYNC  | global align: counter to 0, pending applied, tick suppressed
// MODE_WRAP  | last count of the period: tick next cycle, pending applied
// MODE_COUNT | mid-period: counter advances
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DW      = 24,
  parameter int unsigned DEF_DIV = DEF_DIV_RESET
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [DW-1:0] wr_div,
  output logic          busy,
  output logic          tick,
  output logic          sq
);

  logic [DW-1:0] cnt_q, cnt_nxt;
  logic [DW-1:0] d_act_q, d_act_nxt;
  logic [DW-1:0] d_pend_q, d_pend_nxt;
  logic          pend_v_q, pend_v_nxt;
  logic          tick_q, tick_nxt;
  logic          sq_q, sq_nxt;

  chan_mode_e    mode;
  logic [DW-1:0] d_act_eff;
  logic [DW-1:0] d_nxt_eff;
  logic [DW:0]   half_nxt;
  logic          wrap;
  logic          apply;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      d_act_q  <= DW'(DEF_DIV);
      d_pend_q <= '0;
      pend_v_q <= 1'b0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      d_act_q  <= d_act_nxt;
      d_pend_q <= d_pend_nxt;
      pend_v_q <= pend_v_nxt;
      tick_q   <= tick_nxt;
      sq_q     <= sq_nxt;
    end
  end

  always_comb begin
    mode       = MODE_COUNT;
    d_act_eff  = (d_act_q == '0) ? DW'(1) : d_act_q;
    wrap       = (cnt_q == d_act_eff - DW'(1));

    if (!en)       mode = MODE_HOLD;
    else if (sync) mode = MODE_SYNC;
    else if (wrap) mode = MODE_WRAP;

    // Divisor only changes at a period boundary, so no short period is ever produced.
    apply      = pend_v_q && (mode != MODE_COUNT);
    d_act_nxt  = apply ? d_pend_q : d_act_q;
    d_nxt_eff  = (d_act_nxt == '0) ? DW'(1) : d_act_nxt;
    half_nxt   = ({1'b0, d_nxt_eff} + (DW+1)'(1)) >> 1;

    cnt_nxt    = (mode == MODE_COUNT) ? cnt_q + DW'(1) : '0;
    tick_nxt   = (mode == MODE_WRAP);
    sq_nxt     = (mode != MODE_HOLD) && ({1'b0, cnt_nxt} < half_nxt);

    // A write in an applying cycle lands in pending after the old value has moved to active.
    d_pend_nxt = wr ? wr_div : d_pend_q;
    pend_v_nxt = wr ? 1'b1 : (apply ? 1'b0 : pend_v_q);
  end

  assign busy = pend_v_q;
  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator with glitch-free runtime divisors.
// Optional CLK_DIV_SYNC_EN adds sync_i to phase-align all enabled channels.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter  int unsigned NCH     = 4,
  parameter  int unsigned DW      = 24,
  parameter  int unsigned DEF_DIV = DEF_DIV_RESET,
  localparam int unsigned CHW     = chw_of(NCH)
) (
  input  logic           clk,
  input  logic           rst,
`ifdef CLK_DIV_SYNC_EN
  input  logic           sync_i,
`endif
  input  logic [NCH-1:0] en_i,
  input  logic           cfg_wr_i,
  input  logic [CHW-1:0] cfg_ch_i,
  input  logic [DW-1:0]  cfg_div_i,
  output logic [NCH-1:0] cfg_busy_o,
  output logic [NCH-1:0] tick_o,
  output logic [NCH-1:0] sq_o
);

  logic sync_all;

`ifdef CLK_DIV_SYNC_EN
  assign sync_all = sync_i;
`else
  assign sync_all = 1'b0;
`endif

  // Channel numbers at or above NCH match no instance, so such writes are dropped.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic wr_c;
    assign wr_c = cfg_wr_i && (cfg_ch_i == CHW'(c));

    clk_div_chan #(
      .DW      (DW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en_i[c]),
      .sync   (sync_all),
      .wr     (wr_c),
      .wr_div (cfg_div_i),
      .busy   (cfg_busy_o[c]),
      .tick   (tick_o[c]),
      .sq     (sq_o[c])
    );
  end

endmodule
